// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV64I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port with ack timeout trap.
// Optional RISCV_MC_PERF_EN adds 64-bit cycle_cnt / instret_cnt performance counters.
module riscv_mc_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instr_opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // The cycle that brings the wait count to ACK_TIMEOUT is the last one allowed.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;

  logic w_is_r;
  logic w_is_ialu;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jal;
  logic w_is_lui;
  logic w_legal;
  logic w_br_taken;
  logic w_timeout;

  assign w_is_r      = (instr_opcode == OP_R);
  assign w_is_ialu   = (instr_opcode == OP_IALU);
  assign w_is_load   = (instr_opcode == OP_LOAD);
  assign w_is_store  = (instr_opcode == OP_STORE);
  assign w_is_branch = (instr_opcode == OP_BRANCH);
  assign w_is_jal    = (instr_opcode == OP_JAL);
  assign w_is_lui    = (instr_opcode == OP_LUI);

  // Only BEQ/BNE are implemented among the branches.
  assign w_legal = w_is_r | w_is_ialu | w_is_load | w_is_store | w_is_jal | w_is_lui |
                   (w_is_branch & (funct3[2:1] == 2'b00));

  assign w_br_taken = (zero == ~funct3[0]);
  assign w_timeout  = (r_wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (mem_req && !mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    imm_sel   = 3'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    trap      = 1'b0;

    if (rst_n) begin
      case (instr_opcode)
        OP_STORE:  imm_sel = 3'd1;
        OP_BRANCH: imm_sel = 3'd2;
        OP_LUI:    imm_sel = 3'd3;
        OP_JAL:    imm_sel = 3'd4;
        default:   imm_sel = 3'd0;
      endcase

      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ack) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            w_next = S_DECODE;
          end else if (w_timeout) begin
            w_next = S_TRAP;
          end
        end

        S_DECODE: begin
          alu_src_a = 2'd3;
          alu_src_b = 2'd2;
          w_next    = w_legal ? S_EXEC : S_TRAP;
        end

        S_EXEC: begin
          if (w_is_r) begin
            alu_src_a = 2'd1;
            alu_op    = 2'd2;
            w_next    = S_WB;
          end else if (w_is_ialu) begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_op    = 2'd2;
            w_next    = S_WB;
          end else if (w_is_load || w_is_store) begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            w_next    = S_MEM;
          end else if (w_is_lui) begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd2;
            w_next    = S_WB;
          end else if (w_is_branch) begin
            alu_src_a = 2'd1;
            alu_op    = 2'd1;
            pc_we     = w_br_taken;
            pc_src    = w_br_taken;
            retire    = 1'b1;
            w_next    = S_FETCH;
          end else if (w_is_jal) begin
            // Link value is PC+4, already sitting in PC since FETCH.
            pc_we  = 1'b1;
            pc_src = 1'b1;
            reg_we = 1'b1;
            wb_sel = 2'd2;
            retire = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_TRAP;
          end
        end

        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = w_is_store;
          if (mem_ack) begin
            if (w_is_store) begin
              retire = 1'b1;
              w_next = S_FETCH;
            end else begin
              w_next = S_WB;
            end
          end else if (w_timeout) begin
            w_next = S_TRAP;
          end
        end

        S_WB: begin
          reg_we = 1'b1;
          wb_sel = w_is_load ? 2'd1 : 2'd0;
          retire = 1'b1;
          w_next = S_FETCH;
        end

        S_TRAP: begin
          trap = 1'b1;
        end

        default: begin
          w_next = S_TRAP;
        end
      endcase
    end
  end

`ifdef RISCV_MC_PERF_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      if (r_state != S_TRAP) begin
        r_cycle_cnt <= r_cycle_cnt + 64'd1;
      end
      if (retire) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: per-cycle expected control vectors are queued as stimulus is driven.
module tb_riscv_mc_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_ILL    = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [2:0] imm_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       trap;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] instr_opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic       reg_we, retire, trap;

  logic [6:0] nx_opc;
  logic [2:0] nx_f3;
  logic       nx_zero;

  out_t  act;
  out_t  exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .funct3(funct3),
    .zero(zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire),
    .trap(trap)
  );

  assign act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, imm_sel,
                alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, retire, trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic out_t o_fetch(input logic ack, input logic [2:0] imm);
    out_t e = '0;
    e.mem_req = 1'b1; e.src_b = 2'd1; e.ir_we = ack; e.pc_we = ack; e.imm_sel = imm;
    return e;
  endfunction

  function automatic out_t o_decode(input logic [2:0] imm);
    out_t e = '0;
    e.src_a = 2'd3; e.src_b = 2'd2; e.imm_sel = imm;
    return e;
  endfunction

  function automatic out_t o_exec(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] op, input logic [2:0] imm);
    out_t e = '0;
    e.src_a = a; e.src_b = b; e.alu_op = op; e.imm_sel = imm;
    return e;
  endfunction

  function automatic out_t o_branch(input logic taken);
    out_t e = '0;
    e.src_a = 2'd1; e.alu_op = 2'd1; e.pc_we = taken; e.pc_src = taken;
    e.retire = 1'b1; e.imm_sel = 3'd2;
    return e;
  endfunction

  function automatic out_t o_jal();
    out_t e = '0;
    e.pc_we = 1'b1; e.pc_src = 1'b1; e.reg_we = 1'b1; e.wb_sel = 2'd2;
    e.retire = 1'b1; e.imm_sel = 3'd4;
    return e;
  endfunction

  function automatic out_t o_mem(input logic st, input logic ack, input logic [2:0] imm);
    out_t e = '0;
    e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st; e.retire = st & ack; e.imm_sel = imm;
    return e;
  endfunction

  function automatic out_t o_wb(input logic ld, input logic [2:0] imm);
    out_t e = '0;
    e.reg_we = 1'b1; e.wb_sel = ld ? 2'd1 : 2'd0; e.retire = 1'b1; e.imm_sel = imm;
    return e;
  endfunction

  function automatic out_t o_trap(input logic [2:0] imm);
    out_t e = '0;
    e.trap = 1'b1; e.imm_sel = imm;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic a, input out_t e, input string tag);
    @(negedge clk);
    rst_n        = r;
    mem_ack      = a;
    instr_opcode = nx_opc;
    funct3       = nx_f3;
    zero         = nx_zero;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic z);
    nx_opc = o; nx_f3 = f; nx_zero = z;
  endtask

  always @(negedge clk) begin
    #3;
    if (exp_q.size() != 0) begin
      out_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(act), 32'(e));
    end
  end

  initial begin
    rst_n = 1'b0; mem_ack = 1'b1; instr_opcode = OP_R; funct3 = 3'd0; zero = 1'b0;
    set_instr(OP_R, 3'd0, 1'b0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, $sformatf("reset%0d", i));

    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "add_fetch");
    cyc(1'b1, 1'b1, o_decode(3'd0), "add_decode");
    cyc(1'b1, 1'b0, o_exec(2'd1, 2'd0, 2'd2, 3'd0), "add_exec");
    cyc(1'b1, 1'b1, o_wb(1'b0, 3'd0), "add_wb");

    set_instr(OP_LOAD, 3'd3, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "ld_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd0), "ld_decode");
    cyc(1'b1, 1'b0, o_exec(2'd1, 2'd2, 2'd0, 3'd0), "ld_exec");
    cyc(1'b1, 1'b0, o_mem(1'b0, 1'b0, 3'd0), "ld_mem_w1");
    cyc(1'b1, 1'b0, o_mem(1'b0, 1'b0, 3'd0), "ld_mem_w2");
    cyc(1'b1, 1'b1, o_mem(1'b0, 1'b1, 3'd0), "ld_mem_ack");
    cyc(1'b1, 1'b0, o_wb(1'b1, 3'd0), "ld_wb");

    set_instr(OP_BRANCH, 3'b000, 1'b1);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd2), "beq_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd2), "beq_decode");
    cyc(1'b1, 1'b0, o_branch(1'b1), "beq_z1_exec");

    set_instr(OP_BRANCH, 3'b001, 1'b1);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd2), "bne_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd2), "bne_decode");
    cyc(1'b1, 1'b1, o_branch(1'b0), "bne_z1_exec");

    set_instr(OP_BRANCH, 3'b001, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd2), "bne0_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd2), "bne0_decode");
    cyc(1'b1, 1'b0, o_branch(1'b1), "bne_z0_exec");

    set_instr(OP_BRANCH, 3'b000, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd2), "beq0_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd2), "beq0_decode");
    cyc(1'b1, 1'b0, o_branch(1'b0), "beq_z0_exec");

    set_instr(OP_STORE, 3'd3, 1'b0);
    cyc(1'b1, 1'b0, o_fetch(1'b0, 3'd1), "st_fetch_w");
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd1), "st_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd1), "st_decode");
    cyc(1'b1, 1'b0, o_exec(2'd1, 2'd2, 2'd0, 3'd1), "st_exec");
    cyc(1'b1, 1'b0, o_mem(1'b1, 1'b0, 3'd1), "st_mem_w");
    cyc(1'b1, 1'b1, o_mem(1'b1, 1'b1, 3'd1), "st_mem_ack");

    set_instr(OP_JAL, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd4), "jal_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd4), "jal_decode");
    cyc(1'b1, 1'b0, o_jal(), "jal_exec");

    set_instr(OP_LUI, 3'd5, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd3), "lui_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd3), "lui_decode");
    cyc(1'b1, 1'b0, o_exec(2'd2, 2'd2, 2'd0, 3'd3), "lui_exec");
    cyc(1'b1, 1'b0, o_wb(1'b0, 3'd3), "lui_wb");

    set_instr(OP_IALU, 3'd4, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "addi_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd0), "addi_decode");
    cyc(1'b1, 1'b1, o_exec(2'd1, 2'd2, 2'd2, 3'd0), "addi_exec");
    cyc(1'b1, 1'b0, o_wb(1'b0, 3'd0), "addi_wb");

    set_instr(OP_BRANCH, 3'b010, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd2), "badbr_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd2), "badbr_decode");
    cyc(1'b1, 1'b0, o_trap(3'd2), "badbr_trap");
    cyc(1'b0, 1'b1, '0, "badbr_reset");

    set_instr(OP_ILL, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "ill_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd0), "ill_decode");
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'(i % 2), o_trap(3'd0), $sformatf("ill_trap%0d", i));
    cyc(1'b0, 1'b0, '0, "ill_reset");

    set_instr(OP_R, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, o_fetch(1'b0, 3'd0), $sformatf("to_fetch%0d", i));
    cyc(1'b1, 1'b1, o_trap(3'd0), "to_trap0");
    cyc(1'b1, 1'b0, o_trap(3'd0), "to_trap1");
    cyc(1'b0, 1'b0, '0, "to_reset");

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, o_fetch(1'b0, 3'd0), $sformatf("late_fetch%0d", i));
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "late_fetch_ack");
    cyc(1'b1, 1'b0, o_decode(3'd0), "late_decode");
    cyc(1'b1, 1'b0, o_exec(2'd1, 2'd0, 2'd2, 3'd0), "late_exec");
    cyc(1'b1, 1'b0, o_wb(1'b0, 3'd0), "late_wb");

    set_instr(OP_LOAD, 3'd3, 1'b0);
    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "mto_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd0), "mto_decode");
    cyc(1'b1, 1'b0, o_exec(2'd1, 2'd2, 2'd0, 3'd0), "mto_exec");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, o_mem(1'b0, 1'b0, 3'd0), $sformatf("mto_mem%0d", i));
    cyc(1'b1, 1'b0, o_trap(3'd0), "mto_trap");
    cyc(1'b0, 1'b0, '0, "mto_reset");

    cyc(1'b1, 1'b1, o_fetch(1'b1, 3'd0), "abort_fetch");
    cyc(1'b1, 1'b0, o_decode(3'd0), "abort_decode");
    cyc(1'b1, 1'b0, o_exec(2'd1, 2'd2, 2'd0, 3'd0), "abort_exec");
    cyc(1'b1, 1'b0, o_mem(1'b0, 1'b0, 3'd0), "abort_mem");
    cyc(1'b0, 1'b1, '0, "abort_reset");
    cyc(1'b1, 1'b0, o_fetch(1'b0, 3'd0), "abort_refetch");

    @(negedge clk);
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
